// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; never narrower than one bit so WIDTH=1 still has a counter.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle; master is the upstream/consumer, slave is the block.
interface serial_addsub_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, busy
    );
endinterface

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder built from two half adders and an OR gate.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    logic p, g1, g2;

    assign p     = a ^ b;
    assign g1    = a & b;
    assign s     = p ^ c_in;
    assign g2    = p & c_in;
    assign c_out = g1 | g2;
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/sub reusing a single full-adder cell, LSB first,
// with valid/ready handshakes on operands and result.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_addsub_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] s_shift;

    fa_cell u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_co)
    );

    // Sum bits enter at the MSB so the word is aligned after WIDTH shifts.
    assign s_shift  = WIDTH'({fa_s, s_sr} >> 1);
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_sr          <= '0;
            b_sr          <= '0;
            s_sr          <= '0;
            carry         <= 1'b0;
            cnt           <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.s         <= '0;
            bus.c_out     <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        // Subtract as A + ~B + ~borrow.
                        a_sr         <= bus.a;
                        b_sr         <= bus.b ^ {WIDTH{bus.sub}};
                        carry        <= bus.c_in ^ bus.sub;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_shift;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.s         <= s_shift;
                        bus.c_out     <= fa_co;
                        bus.ovf       <= carry ^ fa_co;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.in_ready  <= 1'b0;
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule
